// File: rtl/rgmii_tx_speed_gen.sv
// rgmii_tx_speed_gen: GMII-to-RGMII ODDR sequencer for 1G/100M/10M with byte-boundary speed switching
module rgmii_tx_speed_gen #(
  parameter int DIV_100 = 5,
  parameter int DIV_10 = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  input  logic [7:0] s_txd,
  input  logic       s_tx_en,
  input  logic       s_tx_er,
  output logic       s_ready,
  output logic       txc_d1,
  output logic       txc_d2,
  output logic [3:0] td_d1,
  output logic [3:0] td_d2,
  output logic       tx_ctl_d1,
  output logic       tx_ctl_d2,
  output logic [1:0] speed_active
);
  localparam int CW = $clog2(DIV_10);
  localparam logic [CW-1:0] M100 = CW'(DIV_100 - 1);
  localparam logic [CW-1:0] M10 = CW'(DIV_10 - 1);
  localparam logic [CW-1:0] H100 = CW'((DIV_100 + 1) / 2);
  localparam logic [CW-1:0] H10 = CW'((DIV_10 + 1) / 2);
  logic [CW-1:0] cnt, cnt_n, dm, dm_n, h_n;
  logic ph, ph_n, wrap, sw, gig_n, txc_n, ready_n, ctl1_n, ctl2_n;
  logic [1:0] spd_req, sa_n;
  logic [9:0] held, held_n;
  logic [3:0] td1_n, td2_n;
  // next-state: speed is re-evaluated only on an accepted byte, so a switch always lands on a byte boundary
  always_comb begin
    spd_req = speed[1] ? 2'b10 : speed;
    sa_n = s_ready ? spd_req : speed_active;
    sw = sa_n != speed_active;
    gig_n = sa_n[1];
    dm = speed_active[0] ? M100 : M10;
    dm_n = sa_n[0] ? M100 : M10;
    h_n = sa_n[0] ? H100 : H10;
    wrap = cnt >= dm;
    cnt_n = (gig_n || sw || wrap) ? '0 : cnt + 1'b1;
    ph_n = (gig_n || sw) ? 1'b0 : ph ^ wrap;
    txc_n = gig_n || (cnt_n < h_n);
    ready_n = gig_n || (ph_n && cnt_n == dm_n);
    held_n = s_ready ? {s_tx_er, s_tx_en, s_txd} : held;
    td1_n = s_ready ? s_txd[3:0] : (!gig_n && wrap && !ph) ? held[7:4] : td_d1;
    td2_n = gig_n ? (s_ready ? s_txd[7:4] : td_d2) : td1_n;
    ctl1_n = gig_n ? (s_ready ? s_tx_en : tx_ctl_d1) : (txc_n ? held_n[8] : held_n[8] ^ held_n[9]);
    ctl2_n = gig_n ? (s_ready ? s_tx_en ^ s_tx_er : tx_ctl_d2) : ctl1_n;
  end
  // register all outputs and sequencing state
  always_ff @(posedge clk) begin
    if (rst) begin
      speed_active <= speed[1] ? 2'b10 : speed;
      cnt <= '0;
      ph <= 1'b0;
      held <= '0;
      s_ready <= 1'b0;
      txc_d1 <= 1'b1;
      txc_d2 <= 1'b0;
      td_d1 <= '0;
      td_d2 <= '0;
      tx_ctl_d1 <= 1'b0;
      tx_ctl_d2 <= 1'b0;
    end else begin
      speed_active <= sa_n;
      cnt <= cnt_n;
      ph <= ph_n;
      held <= held_n;
      s_ready <= ready_n;
      txc_d1 <= txc_n;
      txc_d2 <= !gig_n && txc_n;
      td_d1 <= td1_n;
      td_d2 <= td2_n;
      tx_ctl_d1 <= ctl1_n;
      tx_ctl_d2 <= ctl2_n;
    end
  end
endmodule

// File: tb/tb_rgmii_tx_speed_gen.sv
// tb_rgmii_tx_speed_gen: randomized bench with a byte-position reference model
module tb_rgmii_tx_speed_gen;
  localparam int DIV_100 = 5;
  localparam int DIV_10 = 50;
  logic clk = 0, rst = 1;
  logic [1:0] speed = 2'b10;
  logic [7:0] s_txd = 0;
  logic s_tx_en = 0, s_tx_er = 0;
  logic s_ready, txc_d1, txc_d2, tx_ctl_d1, tx_ctl_d2;
  logic [3:0] td_d1, td_d2;
  logic [1:0] speed_active;
  logic [14:0] obs, exp;
  int vectors = 0, miscompares = 0;
  logic [1:0] m_spd;
  int m_pos;
  logic [9:0] m_held;
  logic e_ready, e_txc1, e_txc2, e_ctl1, e_ctl2;
  logic [3:0] e_td1, e_td2;

  rgmii_tx_speed_gen #(.DIV_100(DIV_100), .DIV_10(DIV_10)) dut (
    .clk(clk), .rst(rst), .speed(speed), .s_txd(s_txd), .s_tx_en(s_tx_en), .s_tx_er(s_tx_er),
    .s_ready(s_ready), .txc_d1(txc_d1), .txc_d2(txc_d2), .td_d1(td_d1), .td_d2(td_d2),
    .tx_ctl_d1(tx_ctl_d1), .tx_ctl_d2(tx_ctl_d2), .speed_active(speed_active)
  );

  always #5 clk = ~clk;
  assign obs = {s_ready, txc_d1, txc_d2, td_d1, td_d2, tx_ctl_d1, tx_ctl_d2, speed_active};

  // reference: position within a 2*DIV byte period; low nibble first half, TXC high for first ceil(DIV/2) of each slot
  task automatic model();
    logic [1:0] ns;
    logic bnd, txc;
    logic [3:0] nib;
    int div;
    ns = speed[1] ? 2'b10 : speed;
    if (rst) begin
      m_spd = ns; m_pos = 0; m_held = '0;
      e_ready = 0; e_txc1 = 1; e_txc2 = 0; e_td1 = 0; e_td2 = 0; e_ctl1 = 0; e_ctl2 = 0;
    end else begin
      bnd = e_ready;
      if (bnd) m_spd = ns;
      if (m_spd[1]) begin
        if (bnd) begin
          e_td1 = s_txd[3:0]; e_td2 = s_txd[7:4]; e_ctl1 = s_tx_en; e_ctl2 = s_tx_en ^ s_tx_er;
        end
        e_txc1 = 1; e_txc2 = 0; e_ready = 1; m_pos = 0;
      end else begin
        div = m_spd[0] ? DIV_100 : DIV_10;
        if (bnd) begin
          m_held = {s_tx_er, s_tx_en, s_txd}; m_pos = 0;
        end else m_pos = (m_pos + 1) % (2 * div);
        nib = (m_pos < div) ? m_held[3:0] : m_held[7:4];
        txc = (m_pos % div) < (div + 1) / 2;
        e_td1 = nib; e_td2 = nib; e_txc1 = txc; e_txc2 = txc;
        e_ctl1 = txc ? m_held[8] : m_held[8] ^ m_held[9]; e_ctl2 = e_ctl1;
        e_ready = m_pos == 2 * div - 1;
      end
    end
    exp = {e_ready, e_txc1, e_txc2, e_td1, e_td2, e_ctl1, e_ctl2, m_spd};
  endtask

  task automatic test_reset();
    rst = 1; speed = 2'b01;
    for (int i = 0; i < 2; i++) begin
      model(); @(posedge clk); #1; vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs, exp); end
    end
    speed = 2'b11;
    model(); @(posedge clk); #1; vectors++;
    if (speed_active !== 2'b10) begin miscompares++; $display("FAIL reset_speed got=%b exp=10", speed_active); end
  endtask

  task automatic test_1g();
    logic [7:0] bytes [0:3];
    logic [1:0] ee [0:3];
    bytes = '{8'h00, 8'h5A, 8'hC3, 8'hFF};
    ee = '{2'b00, 2'b01, 2'b01, 2'b11};
    rst = 1; speed = 2'b10; model(); @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      s_txd = bytes[i]; s_tx_en = ee[i][0]; s_tx_er = ee[i][1];
      model(); @(posedge clk); #1; vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL 1g_directed cyc=%0d got=%h exp=%h", i, obs, exp); end
    end
    vectors++;
    if ({td_d1, td_d2, tx_ctl_d1, tx_ctl_d2} !== {4'hF, 4'hF, 2'b10}) begin
      miscompares++; $display("FAIL 1g_err got=%h exp=ff2", {td_d1, td_d2, tx_ctl_d1, tx_ctl_d2});
    end
    for (int i = 0; i < 40; i++) begin
      s_txd = 8'($urandom); s_tx_en = 1'($urandom); s_tx_er = 1'($urandom);
      model(); @(posedge clk); #1; vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL 1g_random cyc=%0d got=%h exp=%h", i, obs, exp); end
    end
  endtask

  task automatic test_slow(input logic [1:0] spd, input int bytes);
    int div, pulses;
    div = spd[0] ? DIV_100 : DIV_10;
    pulses = 0;
    rst = 1; speed = spd; model(); @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < bytes * 2 * div; i++) begin
      s_txd = 8'($urandom); s_tx_en = 1'($urandom_range(0, 3) != 0); s_tx_er = 1'($urandom);
      model(); @(posedge clk); #1; vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL slow_%b cyc=%0d got=%h exp=%h", spd, i, obs, exp); end
      if (s_ready) pulses++;
    end
    vectors++;
    if (pulses !== bytes) begin miscompares++; $display("FAIL slow_%b_pulses got=%0d exp=%0d", spd, pulses, bytes); end
  endtask

  task automatic test_speed_switch();
    rst = 1; speed = 2'b10; model(); @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) speed = 2'($urandom);
      s_txd = 8'($urandom); s_tx_en = 1'($urandom); s_tx_er = 1'($urandom);
      model(); @(posedge clk); #1; vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL switch cyc=%0d got=%h exp=%h", i, obs, exp); end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    rst = 1; speed = 2'b01; model(); @(posedge clk); #1;
    rst = 0; guard = 0;
    while (!(m_pos == DIV_100 + 2 && guard > 10) && guard < 100) begin
      s_txd = 8'($urandom); s_tx_en = 1; s_tx_er = 1'($urandom);
      model(); @(posedge clk); #1; vectors++; guard++;
      if (obs !== exp) begin miscompares++; $display("FAIL rst_mid_pre cyc=%0d got=%h exp=%h", guard, obs, exp); end
    end
    vectors++;
    if (guard >= 100) begin miscompares++; $display("FAIL rst_mid_reach got=%0d exp=<100", guard); end
    rst = 1; speed = 2'b00;
    model(); @(posedge clk); #1; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL rst_mid_assert got=%h exp=%h", obs, exp); end
    rst = 0; speed = 2'b01;
    for (int i = 0; i < 2 * DIV_10 + 10; i++) begin
      s_txd = 8'($urandom); s_tx_en = 1'($urandom); s_tx_er = 1'($urandom);
      model(); @(posedge clk); #1; vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL rst_mid_post cyc=%0d got=%h exp=%h", i, obs, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_1g();
    test_slow(2'b01, 8);
    test_slow(2'b00, 3);
    test_speed_switch();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
